// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and ALU encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp and funct to ALUControl; funct_valid flags a supported R-type funct
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);
  logic [2:0] r_ctl;
  always_comb begin
    r_ctl = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      F_ADD:   r_ctl = ALU_ADD;
      F_SUB:   r_ctl = ALU_SUB;
      F_AND:   r_ctl = ALU_AND;
      F_OR:    r_ctl = ALU_OR;
      F_SLT:   r_ctl = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
    alu_control_o = alu_op_i == ALUOP_SUB ? ALU_SUB : alu_op_i == ALUOP_FUNCT ? r_ctl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic [STATE_W-1:0] state
);
  state_t state_q, state_d;
  logic [1:0] alu_op;
  logic funct_valid, pc_write, branch, ir_write, reg_write, mem_write;
  always_ff @(posedge clk)
    state_q <= reset ? FETCH : state_d;
  assign alu_op = state_q == EXECUTE ? ALUOP_FUNCT : state_q == BRANCH ? ALUOP_SUB : ALUOP_ADD;
  alu_decoder u_alu_dec (
    .alu_op_i     (alu_op),
    .funct_i      (funct),
    .alu_control_o(ALUControl),
    .funct_valid_o(funct_valid)
  );
  always_comb begin
    state_d = FETCH;
    IorD = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSrc = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                  op == OP_RTYPE ? EXECUTE :
                  op == OP_BEQ   ? BRANCH  :
                  op == OP_ADDI  ? ADDIEX  :
                  op == OP_J     ? JUMP    : FETCH;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = op == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        IorD = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst = 1'b1;
        reg_write = funct_valid;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        PCSrc = 2'b01;
        branch = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        PCSrc = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  // Reset gates the strobes so an aborted instruction never commits anything.
  assign PCEn = ~reset & (pc_write | (branch & zero));
  assign IRWrite = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign MemWrite = ~reset & mem_write;
  assign state = STATE_W'(state_q);
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the 32-bit multicycle MIPS datapath. It sits directly upstream of the register file and drives its write enable (WE3 = RegWrite) and the A3/WD3 source selects (RegDst, MemtoReg).
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback cycles. It also drives the PC, instruction-register and memory enables, the ALU operand selects and ALUControl.

Parameters:
- STATE_W, 4, width of the state encoding; must hold 12 states.

Ports:
- clk  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26], taken from the instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  register file A3 select: 0 = rt, 1 = rd
- MemtoReg  out  1  register file WD3 select: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file WE3
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  ALU operation
- PCSrc  out  2  PC next select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC register enable
- state  out  STATE_W  current state, exposed for the verification bench

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: the state register loads FETCH(0) at the first clk edge with reset high.
  - While reset is high, PCEn, IRWrite, RegWrite and MemWrite are forced to 0, independent of state.
  - Reset asserted mid-instruction aborts that instruction: no write strobe is issued, and FETCH is entered at the next edge.
- Outputs are combinational from the registered state (Moore). The exceptions are PCEn = PCWrite | (Branch & zero) and the R-type ALUControl, which is decoded from funct.
- Any output not listed for a state is 0. In the list below, ALUOp is internal.
- State outputs and transitions:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1 -> DECODE
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by op:
    - 0x23 (lw) / 0x2B (sw) -> MEMADR
    - 0x00 (R-type) -> EXECUTE
    - 0x04 (beq) -> BRANCH
    - 0x08 (addi) -> ADDIEX
    - 0x02 (j) -> JUMP
    - any other op -> FETCH (treated as a NOP, no writes)
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if op=0x23, else MEMWRITE
  - MEMREAD(3): IorD=1 -> MEMWB
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH
  - MEMWRITE(5): IorD=1, MemWrite=1 -> FETCH
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB
  - ALUWB(7): RegDst=1, MemtoReg=0 -> FETCH. RegWrite=1 only if funct is a supported code; otherwise the write is suppressed.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH
  - JUMP(11): PCSrc=10, PCWrite=1 -> FETCH
- Unused encodings 12-15 -> FETCH next cycle, with all strobes 0.
- ALU decode:
  - ALUOp=00 -> 010 (add)
  - ALUOp=01 -> 110 (sub)
  - ALUOp=10 -> by funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111, other -> 010 and funct_valid=0
  - ALUOp=11 -> 010
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined op 2.
- Strobe exclusivity: RegWrite and MemWrite are never both 1 in the same cycle. IRWrite is 1 only in FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum state_t (FETCH..JUMP)
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUOp and ALUControl localparams
- Sub-module alu_decoder (combinational): inputs ALUOp and funct; outputs ALUControl and funct_valid.
- The FSM next-state and output decode stay in multicycle_controller.

Test Plan:
- Hold reset 2 cycles, then release with op=0x00 -> state=0 during reset; PCEn=IRWrite=RegWrite=MemWrite=0 while reset high; PCEn=1 and IRWrite=1 on the first cycle after release.
- lw (op=0x23) -> states 0,1,2,3,4,0; RegWrite=1, MemtoReg=1 only in state 4; IorD=1 in state 3; 5 cycles total.
- R-type add (op=0x00, funct=0x20), then slt (funct=0x2A) -> EXECUTE gives ALUControl=010, then 111; ALUWB gives RegWrite=1, RegDst=1; unsupported funct=0x03 gives RegWrite=0 in ALUWB.
- beq (op=0x04): zero=1 -> PCEn=1, PCSrc=01, ALUControl=110 in state 8; repeat with zero=0 -> PCEn=0; both return to FETCH.
- sw (op=0x2B), then j (op=0x02), then undefined op=0x3F:
  - sw: MemWrite=1 only in state 5, RegWrite never asserted.
  - j: state 11 gives PCEn=1, PCSrc=10.
  - op=0x3F: DECODE -> FETCH, no strobes.
- Assert reset while in MEMREAD during a lw -> next state=0, and RegWrite is never asserted for that lw.
